// File: rtl/memmove_engine_pkg.sv
// Shared types for the memmove copy engine: FSM states, copy direction and
// the upper bound on the supported RAM read latency.
package mem_pkg;

  localparam int RD_LAT_MAX = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_DONE
  } mmv_state_t;

  typedef enum logic {
    FWD,
    BWD
  } mmv_dir_t;

endpackage

// File: rtl/memmove_engine_if.sv
// Control handshake plus single-port RAM port of the memmove engine.
// The slave modport is the engine; master is the control master and RAM.
interface memmove_engine_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dest;
  logic [ADDR_W:0]   num;
  logic              abort;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_ena;
  logic              mem_wr_ena;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  start, src, dest, num, abort, mem_rdata,
    output busy, done, aborted, mem_addr, mem_rd_ena, mem_wr_ena, mem_wdata
  );

  modport master (
    output start, src, dest, num, abort, mem_rdata,
    input  busy, done, aborted, mem_addr, mem_rd_ena, mem_wr_ena, mem_wdata
  );
endinterface

// File: rtl/memmove_engine_addr_gen.sv
// Source/destination address registers and remaining-word counter.
// Picks the copy direction on load and steps both addresses once per word.
module mmv_addr_gen
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dest,
  input  logic [ADDR_W:0]   num,
  output logic [ADDR_W-1:0] src_nxt,
  output logic [ADDR_W-1:0] dst_cur,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [ADDR_W:0]   ONE_N = 1;

  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  mmv_dir_t          dir_q, dir_d;
  logic [ADDR_W-1:0] diff;
  logic [ADDR_W-1:0] span;

  always_comb begin
    diff       = dest - src;
    // num-1 modulo 2^ADDR_W also covers num == 2^ADDR_W (low bits zero)
    span       = num[ADDR_W-1:0] - ONE_A;
    dir_d      = dir_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    rem_d      = rem_q;
    if (load) begin
      dir_d      = ({1'b0, diff} < num) ? BWD : FWD;
      src_addr_d = (dir_d == BWD) ? src + span : src;
      dst_addr_d = (dir_d == BWD) ? dest + span : dest;
      rem_d      = num;
    end else if (step) begin
      src_addr_d = (dir_q == BWD) ? src_addr_q - ONE_A : src_addr_q + ONE_A;
      dst_addr_d = (dir_q == BWD) ? dst_addr_q - ONE_A : dst_addr_q + ONE_A;
      rem_d      = rem_q - ONE_N;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q      <= FWD;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      rem_q      <= '0;
    end else begin
      dir_q      <= dir_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      rem_q      <= rem_d;
    end
  end

  assign src_nxt = src_addr_d;
  assign dst_cur = dst_addr_q;
  assign last    = (rem_q == ONE_N);

endmodule

// File: rtl/memmove_engine.sv
// memmove copy engine: FSM, read-latency wait counter and write-data register.
// All outputs are registered from the next-state decode.
//
//   state   | meaning
//   IDLE    | waiting for start
//   RD      | read strobe at current source address
//   WAIT    | RD_LAT cycles for read data; captured on the last one
//   WR      | write strobe at current destination address, step addresses
//   DONE    | one-cycle done pulse, aborted qualifies it
module memmove_engine
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  memmove_engine_if.slave bus
);

  localparam logic [2:0] WAIT_LOAD = 3'(RD_LAT - 1);

  mmv_state_t        state_q, state_d;
  logic [2:0]        wait_q, wait_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              aborted_q, aborted_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              load;
  logic              step;
  logic              last;
  logic [ADDR_W-1:0] src_nxt;
  logic [ADDR_W-1:0] dst_cur;

  mmv_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .src     (bus.src),
    .dest    (bus.dest),
    .num     (bus.num),
    .src_nxt (src_nxt),
    .dst_cur (dst_cur),
    .last    (last)
  );

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    wdata_d   = wdata_q;
    aborted_d = aborted_q;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          aborted_d = 1'b0;
          if (bus.num == '0 || bus.src == bus.dest) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RD;
            load    = 1'b1;
          end
        end
      end
      ST_RD: begin
        if (bus.abort) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
          wait_d  = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        if (bus.abort) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (wait_q == 3'd0) begin
          state_d = ST_WR;
          wdata_d = bus.mem_rdata;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      ST_WR: begin
        // the write in this cycle always lands; abort only stops the next word
        step = 1'b1;
        if (bus.abort) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (last) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RD) || (state_d == ST_WAIT) || (state_d == ST_WR);
    done_d = (state_d == ST_DONE);
    rd_d   = (state_d == ST_RD);
    wr_d   = (state_d == ST_WR);
    addr_d = rd_d ? src_nxt : (wr_d ? dst_cur : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      wdata_q   <= '0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      wdata_q   <= wdata_d;
      aborted_q <= aborted_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;
  assign bus.mem_rd_ena = rd_q;
  assign bus.mem_wr_ena = wr_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_memmove_engine.sv
// Bench for memmove_engine: two instances (RD_LAT 1 and 3), each with its own
// synchronous RAM model, checked against a plain memmove reference.
module tb_memmove_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  memmove_engine_if #(.ADDR_W(8), .DATA_W(8)) ifa ();
  memmove_engine_if #(.ADDR_W(8), .DATA_W(8)) ifb ();

  memmove_engine #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  memmove_engine #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  logic       rd_w [2], wr_w [2], busy_w [2], done_w [2], ab_w [2];
  logic [7:0] addr_w [2], wd_w [2];
  logic [7:0] pipe [2][4];
  logic [7:0] ram [2][256];
  logic       bw_en;
  logic [7:0] bw_addr, bw_d0, bw_d1;
  logic       clr_req [2];
  int         busy_cyc [2], rd_cnt [2], wr_cnt [2], both_cnt [2], first_wr [2];
  int         n_cmp = 0;
  int         n_bad = 0;

  assign rd_w[0] = ifa.mem_rd_ena;  assign rd_w[1] = ifb.mem_rd_ena;
  assign wr_w[0] = ifa.mem_wr_ena;  assign wr_w[1] = ifb.mem_wr_ena;
  assign busy_w[0] = ifa.busy;      assign busy_w[1] = ifb.busy;
  assign done_w[0] = ifa.done;      assign done_w[1] = ifb.done;
  assign ab_w[0] = ifa.aborted;     assign ab_w[1] = ifb.aborted;
  assign addr_w[0] = ifa.mem_addr;  assign addr_w[1] = ifb.mem_addr;
  assign wd_w[0] = ifa.mem_wdata;   assign wd_w[1] = ifb.mem_wdata;
  assign ifa.mem_rdata = pipe[0][0];
  assign ifb.mem_rdata = pipe[1][2];

  // RAM with read pipeline; stage 0 holds junk when no read was issued
  task automatic mon(input int d);
    if (bw_en) ram[d][bw_addr] <= (d == 0) ? bw_d0 : bw_d1;
    else if (wr_w[d]) ram[d][addr_w[d]] <= wd_w[d];
    pipe[d][0] <= rd_w[d] ? ram[d][addr_w[d]] : 8'($urandom);
    pipe[d][1] <= pipe[d][0];
    pipe[d][2] <= pipe[d][1];
    pipe[d][3] <= pipe[d][2];
    if (clr_req[d]) begin
      busy_cyc[d] <= 0; rd_cnt[d] <= 0; wr_cnt[d] <= 0;
      both_cnt[d] <= 0; first_wr[d] <= -1;
    end else begin
      if (busy_w[d]) busy_cyc[d] <= busy_cyc[d] + 1;
      if (rd_w[d]) rd_cnt[d] <= rd_cnt[d] + 1;
      if (wr_w[d]) begin
        wr_cnt[d] <= wr_cnt[d] + 1;
        if (first_wr[d] < 0) first_wr[d] <= int'(addr_w[d]);
      end
      if (rd_w[d] && wr_w[d]) both_cnt[d] <= both_cnt[d] + 1;
    end
  endtask

  always @(posedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic st, input int s, input int t, input int n);
    if (d == 0) begin
      ifa.start = st; ifa.src = 8'(s); ifa.dest = 8'(t); ifa.num = 9'(n);
    end else begin
      ifb.start = st; ifb.src = 8'(s); ifb.dest = 8'(t); ifb.num = 9'(n);
    end
  endtask

  task automatic set_abort(input int d, input logic v);
    if (d == 0) ifa.abort = v;
    else        ifb.abort = v;
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk({tag, ".busy"},    busy_w[d], 0);
    chk({tag, ".done"},    done_w[d], 0);
    chk({tag, ".aborted"}, ab_w[d],   0);
    chk({tag, ".rd_ena"},  rd_w[d],   0);
    chk({tag, ".wr_ena"},  wr_w[d],   0);
    chk({tag, ".addr"},    addr_w[d], 0);
    chk({tag, ".wdata"},   wd_w[d],   0);
  endtask

  // One transfer. ab_cyc>0 raises abort during that cycle after the start
  // edge (cycle 1 = first busy cycle); exp_words is how many writes land.
  task automatic xfer(input string tag, input int d, input int s, input int t, input int n,
                      input int ab_cyc, input int exp_words, input bit mid_start,
                      output int fw);
    logic [7:0] exp_img [256];
    int L, k, done_cyc, exp_done, rw0, bad, bad_a;
    bit bwd, degen, got_ab, got_busy;
    L     = (d == 0) ? 1 : 3;
    degen = (n == 0) || (s == t);
    for (int a = 0; a < 256; a++) exp_img[a] = ram[d][a];
    bwd = !degen && (((t - s) & 255) < n);
    for (int i = 0; i < exp_words; i++) begin
      int j;
      j = bwd ? (n - 1 - i) : i;
      exp_img[(t + j) & 255] = ram[d][(s + j) & 255];
    end
    exp_done = (ab_cyc > 0) ? ab_cyc + 1 : (degen ? 1 : n * (L + 2) + 1);

    @(negedge clk);
    clr_req[d] = 1'b1;
    drive(d, 1'b1, s, t, n);
    @(posedge clk);
    @(negedge clk);
    clr_req[d] = 1'b0;
    drive(d, 1'b0, s, t, n);
    k = 1; done_cyc = 0; got_ab = 1'b0; got_busy = 1'b1;
    while (k < 3000) begin
      if (done_w[d]) begin
        done_cyc = k; got_ab = ab_w[d]; got_busy = busy_w[d];
        set_abort(d, 1'b0);
        if (mid_start) drive(d, 1'b1, s ^ 8'h5a, t ^ 8'h33, 2);
        break;
      end
      set_abort(d, k == ab_cyc);
      if (mid_start && k == 4) drive(d, 1'b1, s ^ 8'h55, t ^ 8'h0f, 3);
      if (mid_start && k == 5) drive(d, 1'b0, s ^ 8'h55, t ^ 8'h0f, 3);
      @(negedge clk);
      k++;
    end
    chk({tag, ".done_cycle"},   done_cyc, exp_done);
    chk({tag, ".aborted"},      got_ab, (ab_cyc > 0) ? 1 : 0);
    chk({tag, ".busy_at_done"}, got_busy, 0);
    chk({tag, ".busy_cycles"},  busy_cyc[d], exp_done - 1);
    chk({tag, ".writes"},       wr_cnt[d], exp_words);
    if (ab_cyc == 0) chk({tag, ".reads"}, rd_cnt[d], exp_words);
    rw0 = rd_cnt[d] + wr_cnt[d];
    @(negedge clk);
    drive(d, 1'b0, s, t, n);
    chk({tag, ".done_pulse"}, done_w[d], 0);
    repeat (3) @(negedge clk);
    chk({tag, ".no_more_strobes"}, rd_cnt[d] + wr_cnt[d], rw0);
    chk({tag, ".idle_after"},      busy_w[d], 0);
    chk({tag, ".rd_wr_overlap"},   both_cnt[d], 0);
    bad = 0; bad_a = -1;
    for (int a = 0; a < 256; a++)
      if (ram[d][a] !== exp_img[a]) begin
        bad++;
        if (bad_a < 0) bad_a = a;
      end
    chk({tag, ".ram_bad_words"}, bad, 0);
    if (bad != 0) chk({tag, ".first_bad_addr"}, bad_a, -1);
    fw = first_wr[d];
  endtask

  initial begin
    int fw, s, t, n;
    rst_n = 1'b0;
    bw_en = 1'b0; bw_addr = '0; bw_d0 = '0; bw_d1 = '0;
    clr_req[0] = 1'b1; clr_req[1] = 1'b1;
    drive(0, 1'b0, 0, 0, 0); drive(1, 1'b0, 0, 0, 0);
    set_abort(0, 1'b0); set_abort(1, 1'b0);
    repeat (3) @(negedge clk);
    chk_idle(0, "reset_a");
    chk_idle(1, "reset_b");
    rst_n = 1'b1;
    clr_req[0] = 1'b0; clr_req[1] = 1'b0;

    for (int a = 0; a < 256; a++) begin
      bw_en = 1'b1; bw_addr = 8'(a);
      bw_d0 = 8'($urandom); bw_d1 = 8'($urandom);
      @(negedge clk);
    end
    bw_en = 1'b0;
    @(negedge clk);

    xfer("fwd_disjoint", 0, 0, 16, 8, 0, 8, 1'b0, fw);
    xfer("bwd_overlap",  0, 0, 4, 8, 0, 8, 1'b0, fw);
    chk("bwd_overlap.first_wr_addr", fw, 11);
    xfer("fwd_overlap",  0, 4, 0, 8, 0, 8, 1'b0, fw);
    chk("fwd_overlap.first_wr_addr", fw, 0);
    xfer("wrap",         0, 252, 2, 6, 0, 6, 1'b0, fw);
    xfer("num_zero",     0, 5, 7, 0, 0, 0, 1'b0, fw);
    xfer("src_eq_dest",  0, 9, 9, 5, 0, 0, 1'b0, fw);
    xfer("start_busy",   0, 30, 60, 10, 0, 10, 1'b1, fw);
    for (int i = 0; i < 5; i++) begin
      s = int'($urandom_range(0, 255));
      t = int'($urandom_range(0, 255));
      n = int'($urandom_range(1, 40));
      xfer($sformatf("rnd_a%0d", i), 0, s, t, n, 0, (s == t) ? 0 : n, 1'b0, fw);
    end

    xfer("lat3_fwd",      1, 10, 100, 6, 0, 6, 1'b0, fw);
    xfer("lat3_bwd_wrap", 1, 250, 253, 7, 0, 7, 1'b0, fw);
    xfer("abort_wait",    1, 40, 140, 6, 13, 2, 1'b0, fw);
    xfer("abort_wr",      1, 60, 160, 6, 15, 3, 1'b0, fw);
    xfer("after_abort",   1, 70, 20, 4, 0, 4, 1'b0, fw);
    for (int i = 0; i < 3; i++) begin
      s = int'($urandom_range(0, 255));
      t = int'($urandom_range(0, 255));
      n = int'($urandom_range(1, 20));
      xfer($sformatf("rnd_b%0d", i), 1, s, t, n, 0, (s == t) ? 0 : n, 1'b0, fw);
    end

    // reset while the L=1 engine sits in WAIT of its first word
    @(negedge clk);
    drive(0, 1'b1, 40, 80, 4);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 40, 80, 4);
    @(negedge clk);
    chk("rst_mid.in_wait_busy", busy_w[0], 1);
    rst_n = 1'b0;
    #1;
    chk_idle(0, "rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    xfer("after_reset", 0, 40, 80, 4, 0, 4, 1'b0, fw);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
